// File: rtl/jitdom_decoder_pkg.sv
// Shared types for the JIT-domain decoder: domain encoding, op codes, scoreboard entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jitdom_decoder_pkg;

  // Domain identifiers. As the current domain, DOMI disables checking.
  // As a code domain, DOMI means "DOM0 or DOM1".
  typedef enum logic [1:0] {
    DOM0 = 2'd0,
    DOM1 = 2'd1,
    DOM2 = 2'd2,
    DOMI = 2'd3
  } dmp_domain_t;

  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

  // Major opcodes handled by this decoder
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LOAD1  = 7'h0B;
  localparam logic [6:0] OPC_STORE1 = 7'h2B;
  localparam logic [6:0] OPC_DOM    = 7'h5B;

  typedef enum logic [4:0] {
    OP_OTHER,
    OP_ILLEGAL,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_LB1, OP_LH1, OP_LW1, OP_LD1, OP_LST,
    OP_SB1, OP_SH1, OP_SW1, OP_SD1, OP_SST,
    OP_CHDOM, OP_RETDOM
  } op_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    op_t         op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    dmp_domain_t code_dom;
    dmp_domain_t data_dom;
    logic        chg_dom;
    exception_t  ex;
  } scoreboard_entry_t;

endpackage

// File: rtl/jitdom_decoder_if.sv
// Issue-path bundle between fetch/issue (master) and the domain decoder (slave).
// Latency: decode fields are combinational; violation record is registered.
// Backpressure: none, the decoder accepts every slot.
interface jitdom_decoder_if;
  import jitdom_decoder_pkg::*;

  logic              valid;
  logic [63:0]       pc;
  logic [31:0]       instruction;
  dmp_domain_t       curdom;
  scoreboard_entry_t entry;
  logic              is_control_flow;
  logic              viol_valid;
  logic [63:0]       viol_pc;
  logic [15:0]       viol_cnt;

  modport master (
    output valid, pc, instruction, curdom,
    input  entry, is_control_flow, viol_valid, viol_pc, viol_cnt
  );

  modport slave (
    input  valid, pc, instruction, curdom,
    output entry, is_control_flow, viol_valid, viol_pc, viol_cnt
  );

endinterface

// File: rtl/jitdom_decoder_perm_check.sv
// Decides whether the current domain may execute an instruction of a given code domain.
// Latency: combinational.
// Backpressure: none.
module jitdom_perm_check
  import jitdom_decoder_pkg::*;
(
  input  dmp_domain_t curdom,
  input  dmp_domain_t code_dom,
  output logic        allowed
);

  // DOMI as current domain bypasses the check; DOMI as code domain accepts DOM0/DOM1
  always_comb begin
    allowed = 1'b0;
    if (curdom == DOMI) begin
      allowed = 1'b1;
    end else if (code_dom == DOMI) begin
      allowed = (curdom == DOM0) || (curdom == DOM1);
    end else begin
      allowed = (curdom == code_dom);
    end
  end

endmodule

// File: rtl/jitdom_decoder.sv
// Domain-aware decoder for loads/stores and JIT-domain custom ops; records last violation.
// Latency: decode is combinational (0 cycles); violation record updates on the next clk_i edge.
// Backpressure: none. Optional counter under JITDOM_VIOL_CNT_EN (saturating 16-bit).
module jitdom_decoder
  import jitdom_decoder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  jitdom_decoder_if.slave   bus
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  op_t               op;
  dmp_domain_t       code_dom;
  dmp_domain_t       data_dom;
  logic              chg_dom;
  logic              enc_illegal;
  logic              is_store;
  logic              allowed;
  logic              ex_valid;
  logic [63:0]       imm;
  scoreboard_entry_t entry;
  logic              capture;
  logic              viol_valid_q;
  logic [63:0]       viol_pc_q;

  assign opcode = bus.instruction[6:0];
  assign funct3 = bus.instruction[14:12];

  // Classify the instruction into op and domain attributes; unknown funct3 is encoding-illegal
  always_comb begin
    op          = OP_OTHER;
    code_dom    = DOMI;
    data_dom    = DOM0;
    chg_dom     = 1'b0;
    enc_illegal = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        case (funct3)
          3'd0:    op = OP_LB;
          3'd1:    op = OP_LH;
          3'd2:    op = OP_LW;
          3'd3:    op = OP_LD;
          3'd4:    op = OP_LBU;
          3'd5:    op = OP_LHU;
          3'd6:    op = OP_LWU;
          default: enc_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'd0:    op = OP_SB;
          3'd1:    op = OP_SH;
          3'd2:    op = OP_SW;
          3'd3:    op = OP_SD;
          default: enc_illegal = 1'b1;
        endcase
      end
      OPC_LOAD1: begin
        code_dom = DOM1;
        data_dom = DOM1;
        case (funct3)
          3'd0:    op = OP_LB1;
          3'd1:    op = OP_LH1;
          3'd2:    op = OP_LW1;
          3'd3:    op = OP_LD1;
          3'd7: begin
            op       = OP_LST;
            data_dom = DOM2;
          end
          default: enc_illegal = 1'b1;
        endcase
      end
      OPC_STORE1: begin
        code_dom = DOM1;
        data_dom = DOM1;
        case (funct3)
          3'd0:    op = OP_SB1;
          3'd1:    op = OP_SH1;
          3'd2:    op = OP_SW1;
          3'd3:    op = OP_SD1;
          3'd7: begin
            op       = OP_SST;
            data_dom = DOM2;
          end
          default: enc_illegal = 1'b1;
        endcase
      end
      OPC_DOM: begin
        case (funct3)
          3'd1: begin
            op       = OP_CHDOM;
            code_dom = DOM0;
            data_dom = DOM1;
            chg_dom  = 1'b1;
          end
          3'd2: begin
            op       = OP_RETDOM;
            code_dom = DOM1;
            data_dom = DOM0;
            chg_dom  = 1'b1;
          end
          default: enc_illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
    // Encoding-illegal slots fall back to the neutral domain attributes
    if (enc_illegal) begin
      op       = OP_ILLEGAL;
      code_dom = DOMI;
      data_dom = DOM0;
      chg_dom  = 1'b0;
    end
  end

  jitdom_perm_check u_perm_check (
    .curdom   (bus.curdom),
    .code_dom (code_dom),
    .allowed  (allowed)
  );

  assign ex_valid = enc_illegal | ~allowed;
  assign is_store = (opcode == OPC_STORE) || (opcode == OPC_STORE1);
  assign imm      = is_store
                  ? {{52{bus.instruction[31]}}, bus.instruction[31:25], bus.instruction[11:7]}
                  : {{52{bus.instruction[31]}}, bus.instruction[31:20]};

  // Assemble the scoreboard entry; cause/tval stay zero unless an exception is raised
  always_comb begin
    entry          = '0;
    entry.pc       = bus.pc;
    entry.op       = op;
    entry.rs1      = bus.instruction[19:15];
    entry.rs2      = bus.instruction[24:20];
    entry.rd       = bus.instruction[11:7];
    entry.imm      = imm;
    entry.code_dom = code_dom;
    entry.data_dom = data_dom;
    entry.chg_dom  = chg_dom;
    entry.ex.valid = ex_valid;
    if (ex_valid) begin
      entry.ex.cause = ILLEGAL_INSTR;
      entry.ex.tval  = {32'd0, bus.instruction};
    end
  end

  assign bus.entry           = entry;
  assign bus.is_control_flow = (op == OP_CHDOM) || (op == OP_RETDOM);

  assign capture = bus.valid & ex_valid;

  // Keep the PC of the most recent violation on a real issue slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      viol_valid_q <= 1'b0;
      viol_pc_q    <= '0;
    end else if (capture) begin
      viol_valid_q <= 1'b1;
      viol_pc_q    <= bus.pc;
    end
  end

  assign bus.viol_valid = viol_valid_q;
  assign bus.viol_pc    = viol_pc_q;

`ifdef JITDOM_VIOL_CNT_EN
  logic [15:0] viol_cnt_q;

  // Count captured violations, holding at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      viol_cnt_q <= '0;
    end else if (capture && (viol_cnt_q != 16'hFFFF)) begin
      viol_cnt_q <= viol_cnt_q + 16'd1;
    end
  end

  assign bus.viol_cnt = viol_cnt_q;
`else
  assign bus.viol_cnt = '0;
`endif

endmodule

// File: tb/tb_jitdom_decoder.sv
// Self-checking bench for jitdom_decoder: directed table, capture/reset sequences, random vs model.
// Latency: decode checked #1 after inputs settle; capture checked #1 after the rising edge.
// Backpressure: none.
module tb_jitdom_decoder;
  import jitdom_decoder_pkg::*;

`ifdef JITDOM_VIOL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  jitdom_decoder_if bus ();

  jitdom_decoder dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    op_t         op;
    dmp_domain_t code;
    dmp_domain_t data;
    logic        chg;
    logic        ex;
    logic [63:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    dmp_domain_t cur;
    exp_t        e;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  op_t load_tab  [8] = '{OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU, OP_ILLEGAL};
  op_t store_tab [8] = '{OP_SB, OP_SH, OP_SW, OP_SD, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL};
  op_t load1_tab [8] = '{OP_LB1, OP_LH1, OP_LW1, OP_LD1, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_LST};
  op_t store1_tab[8] = '{OP_SB1, OP_SH1, OP_SW1, OP_SD1, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_SST};
  op_t dom_tab   [8] = '{OP_ILLEGAL, OP_CHDOM, OP_RETDOM, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic row(input logic [31:0] ins, input dmp_domain_t cur, input op_t op,
                     input dmp_domain_t code, input dmp_domain_t data, input logic chg,
                     input logic ex, input logic [63:0] imm);
    vec_t v;
    v.ins    = ins;
    v.cur    = cur;
    v.e.op   = op;
    v.e.code = code;
    v.e.data = data;
    v.e.chg  = chg;
    v.e.ex   = ex;
    v.e.imm  = imm;
    tbl.push_back(v);
  endtask

  // Reference decode: table lookup by opcode/funct3 plus a domain-set permission rule
  function automatic exp_t ref_decode(input logic [31:0] ins, input dmp_domain_t cur);
    exp_t        e;
    logic [2:0]  f3;
    logic [3:0]  may_exec;
    f3 = ins[14:12];
    e.op = OP_OTHER; e.code = DOMI; e.data = DOM0; e.chg = 1'b0;
    case (ins[6:0])
      7'h03: e.op = load_tab[f3];
      7'h23: e.op = store_tab[f3];
      7'h0B: begin e.op = load1_tab[f3];  e.code = DOM1; e.data = (f3 == 3'd7) ? DOM2 : DOM1; end
      7'h2B: begin e.op = store1_tab[f3]; e.code = DOM1; e.data = (f3 == 3'd7) ? DOM2 : DOM1; end
      7'h5B: begin
        e.op = dom_tab[f3];
        if (f3 == 3'd1) begin e.code = DOM0; e.data = DOM1; e.chg = 1'b1; end
        if (f3 == 3'd2) begin e.code = DOM1; e.data = DOM0; e.chg = 1'b1; end
      end
      default: ;
    endcase
    if (e.op == OP_ILLEGAL) begin e.code = DOMI; e.data = DOM0; e.chg = 1'b0; end
    may_exec = (e.code == DOMI) ? 4'b0011 : (4'b0001 << e.code);
    e.ex = (e.op == OP_ILLEGAL) || ((cur != DOMI) && !may_exec[cur]);
    if (ins[6:0] == 7'h23 || ins[6:0] == 7'h2B)
      e.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    else
      e.imm = {{52{ins[31]}}, ins[31:20]};
    return e;
  endfunction

  task automatic check_entry(input string tag, input exp_t e, input logic [31:0] ins,
                             input logic [63:0] pc);
    check({tag, ".op"},    bus.entry.op,       e.op);
    check({tag, ".code"},  bus.entry.code_dom, e.code);
    check({tag, ".data"},  bus.entry.data_dom, e.data);
    check({tag, ".chg"},   bus.entry.chg_dom,  e.chg);
    check({tag, ".cf"},    bus.is_control_flow, e.chg);
    check({tag, ".ex"},    bus.entry.ex.valid, e.ex);
    check({tag, ".cause"}, bus.entry.ex.cause, e.ex ? 64'd2 : 64'd0);
    check({tag, ".tval"},  bus.entry.ex.tval,  e.ex ? {32'd0, ins} : 64'd0);
    check({tag, ".imm"},   bus.entry.imm,      e.imm);
    check({tag, ".rd"},    bus.entry.rd,       ins[11:7]);
    check({tag, ".rs1"},   bus.entry.rs1,      ins[19:15]);
    check({tag, ".rs2"},   bus.entry.rs2,      ins[24:20]);
    check({tag, ".pc"},    bus.entry.pc,       pc);
  endtask

  task automatic drive(input logic [31:0] ins, input dmp_domain_t cur,
                       input logic [63:0] pc, input logic vld);
    @(negedge clk_i);
    bus.instruction = ins;
    bus.curdom      = cur;
    bus.pc          = pc;
    bus.valid       = vld;
    #1;
  endtask

  task automatic check_viol(input string tag, input logic v, input logic [63:0] pc,
                            input logic [15:0] cnt);
    check({tag, ".viol_valid"}, bus.viol_valid, v);
    check({tag, ".viol_pc"},    bus.viol_pc,    pc);
    check({tag, ".viol_cnt"},   bus.viol_cnt,   cnt);
  endtask

  initial begin
    logic        m_vld;
    logic [63:0] m_pc;
    logic [15:0] m_cnt;
    bus.valid = 1'b0; bus.pc = '0; bus.instruction = '0; bus.curdom = DOMI;

    // Reset state
    #2;
    check_viol("reset", 1'b0, 64'd0, 16'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed decode table
    row(32'h02830383, DOMI, OP_LB,      DOMI, DOM0, 1'b0, 1'b0, 64'd40);
    row(32'h02830383, DOM0, OP_LB,      DOMI, DOM0, 1'b0, 1'b0, 64'd40);
    row(32'h02830383, DOM1, OP_LB,      DOMI, DOM0, 1'b0, 1'b0, 64'd40);
    row(32'h02830383, DOM2, OP_LB,      DOMI, DOM0, 1'b0, 1'b1, 64'd40);
    row(32'h02730423, DOMI, OP_SB,      DOMI, DOM0, 1'b0, 1'b0, 64'd40);
    row(32'h02730423, DOM0, OP_SB,      DOMI, DOM0, 1'b0, 1'b0, 64'd40);
    row(32'h02730423, DOM1, OP_SB,      DOMI, DOM0, 1'b0, 1'b0, 64'd40);
    row(32'h02730423, DOM2, OP_SB,      DOMI, DOM0, 1'b0, 1'b1, 64'd40);
    row(32'h0283038b, DOMI, OP_LB1,     DOM1, DOM1, 1'b0, 1'b0, 64'd40);
    row(32'h0283038b, DOM0, OP_LB1,     DOM1, DOM1, 1'b0, 1'b1, 64'd40);
    row(32'h0283038b, DOM1, OP_LB1,     DOM1, DOM1, 1'b0, 1'b0, 64'd40);
    row(32'h0283038b, DOM2, OP_LB1,     DOM1, DOM1, 1'b0, 1'b1, 64'd40);
    row(32'h0273042b, DOMI, OP_SB1,     DOM1, DOM1, 1'b0, 1'b0, 64'd40);
    row(32'h0273042b, DOM0, OP_SB1,     DOM1, DOM1, 1'b0, 1'b1, 64'd40);
    row(32'h0273042b, DOM1, OP_SB1,     DOM1, DOM1, 1'b0, 1'b0, 64'd40);
    row(32'h0273042b, DOM2, OP_SB1,     DOM1, DOM1, 1'b0, 1'b1, 64'd40);
    row(32'h0283738b, DOMI, OP_LST,     DOM1, DOM2, 1'b0, 1'b0, 64'd40);
    row(32'h0283738b, DOM0, OP_LST,     DOM1, DOM2, 1'b0, 1'b1, 64'd40);
    row(32'h0283738b, DOM1, OP_LST,     DOM1, DOM2, 1'b0, 1'b0, 64'd40);
    row(32'h0283738b, DOM2, OP_LST,     DOM1, DOM2, 1'b0, 1'b1, 64'd40);
    row(32'h028373ab, DOMI, OP_SST,     DOM1, DOM2, 1'b0, 1'b0, 64'd39);
    row(32'h028373ab, DOM0, OP_SST,     DOM1, DOM2, 1'b0, 1'b1, 64'd39);
    row(32'h028373ab, DOM1, OP_SST,     DOM1, DOM2, 1'b0, 1'b0, 64'd39);
    row(32'h028373ab, DOM2, OP_SST,     DOM1, DOM2, 1'b0, 1'b1, 64'd39);
    row(32'h0003105b, DOMI, OP_CHDOM,   DOM0, DOM1, 1'b1, 1'b0, 64'd0);
    row(32'h0003105b, DOM0, OP_CHDOM,   DOM0, DOM1, 1'b1, 1'b0, 64'd0);
    row(32'h0003105b, DOM1, OP_CHDOM,   DOM0, DOM1, 1'b1, 1'b1, 64'd0);
    row(32'h0003105b, DOM2, OP_CHDOM,   DOM0, DOM1, 1'b1, 1'b1, 64'd0);
    row(32'h0003205b, DOMI, OP_RETDOM,  DOM1, DOM0, 1'b1, 1'b0, 64'd0);
    row(32'h0003205b, DOM0, OP_RETDOM,  DOM1, DOM0, 1'b1, 1'b1, 64'd0);
    row(32'h0003205b, DOM1, OP_RETDOM,  DOM1, DOM0, 1'b1, 1'b0, 64'd0);
    row(32'h0003205b, DOM2, OP_RETDOM,  DOM1, DOM0, 1'b1, 1'b1, 64'd0);
    row(32'h0000400b, DOMI, OP_ILLEGAL, DOMI, DOM0, 1'b0, 1'b1, 64'd0);
    row(32'h00000033, DOM2, OP_OTHER,   DOMI, DOM0, 1'b0, 1'b1, 64'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].ins, tbl[i].cur, 64'h1000 + 64'(i) * 64'd4, 1'b0);
      check_entry($sformatf("tbl%0d", i), tbl[i].e, tbl[i].ins, 64'h1000 + 64'(i) * 64'd4);
    end
    @(posedge clk_i); #1;
    check_viol("no_valid", 1'b0, 64'd0, 16'd0);

    // Capture sequence
    drive(32'h02830383, DOM2, 64'h80000000, 1'b0);
    @(posedge clk_i); #1;
    check_viol("cap_invalid", 1'b0, 64'd0, 16'd0);
    drive(32'h02830383, DOM2, 64'h80000000, 1'b1);
    @(posedge clk_i); #1;
    check_viol("cap_first", 1'b1, 64'h80000000, CNT_EN ? 16'd1 : 16'd0);
    drive(32'h02830383, DOM0, 64'h90000000, 1'b1);
    @(posedge clk_i); #1;
    check_viol("cap_legal", 1'b1, 64'h80000000, CNT_EN ? 16'd1 : 16'd0);
    drive(32'h0000400b, DOMI, 64'h80000040, 1'b1);
    @(posedge clk_i); #1;
    check_viol("cap_over", 1'b1, 64'h80000040, CNT_EN ? 16'd2 : 16'd0);

    // Asynchronous reset mid-operation: capture clears, decode unaffected
    drive(32'h0000400b, DOMI, 64'h80000040, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    check_viol("midrst", 1'b0, 64'd0, 16'd0);
    check("midrst.ex", bus.entry.ex.valid, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Randomized stimulus against the reference model
    m_vld = 1'b0; m_pc = '0; m_cnt = '0;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [63:0] pc;
      logic        vld;
      dmp_domain_t cur;
      exp_t        e;
      ins = $urandom;
      case ($urandom_range(0, 5))
        0: ins[6:0] = 7'h03;
        1: ins[6:0] = 7'h23;
        2: ins[6:0] = 7'h0B;
        3: ins[6:0] = 7'h2B;
        4: ins[6:0] = 7'h5B;
        default: ;
      endcase
      pc  = {$urandom, $urandom};
      vld = 1'($urandom_range(0, 1));
      cur = dmp_domain_t'($urandom_range(0, 3));
      drive(ins, cur, pc, vld);
      e = ref_decode(ins, cur);
      check_entry($sformatf("rnd%0d", i), e, ins, pc);
      @(posedge clk_i);
      if (vld && e.ex) begin
        m_vld = 1'b1;
        m_pc  = pc;
        if (CNT_EN && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      #1;
      check_viol($sformatf("rnd%0d", i), m_vld, m_pc, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
